// File: rtl/axi4_lite_gpu_regs.sv
// rtl/axi4_lite_gpu_regs.sv - AXI4-Lite GPU control registers, pixel push port and fill engine
// Optional fill engine and FILL_COLOR/FILL_COUNT registers: define GPU_FILL_ENGINE_EN.
module axi4_lite_gpu_regs #(
    parameter int AXI_ADDRESS_WIDTH = 32,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int FBUF_ADDR_WIDTH   = 19,
    parameter int FBUF_DATA_WIDTH   = 8,
    parameter int NUM_SCRATCH       = 4
) (
    input  logic                           s_axi_ctrl_aclk,
    input  logic                           s_axi_ctrl_aresetn,
    input  logic [AXI_ADDRESS_WIDTH-1:0]   s_axi_ctrl_araddr,
    input  logic                           s_axi_ctrl_arvalid,
    output logic                           s_axi_ctrl_arready,
    output logic [AXI_DATA_WIDTH-1:0]      s_axi_ctrl_rdata,
    output logic [1:0]                     s_axi_ctrl_rresp,
    output logic                           s_axi_ctrl_rvalid,
    input  logic                           s_axi_ctrl_rready,
    input  logic [AXI_ADDRESS_WIDTH-1:0]   s_axi_ctrl_awaddr,
    input  logic                           s_axi_ctrl_awvalid,
    output logic                           s_axi_ctrl_awready,
    input  logic [AXI_DATA_WIDTH-1:0]      s_axi_ctrl_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]    s_axi_ctrl_wstrb,
    input  logic                           s_axi_ctrl_wvalid,
    output logic                           s_axi_ctrl_wready,
    output logic [1:0]                     s_axi_ctrl_bresp,
    output logic                           s_axi_ctrl_bvalid,
    input  logic                           s_axi_ctrl_bready,
    output logic                           fbuf_en_wr,
    output logic                           fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0]     fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0]     fbuf_data
);
    localparam int SW = AXI_DATA_WIDTH / 8;
    localparam int NS = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_RESP} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    logic aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic awready_q, wready_q, arready_q, do_write;
    logic aw_hs, w_hs, ar_hs;
    logic [5:0] awoff_q, ar_off;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, rdata_q, rd_val;
    logic [SW-1:0] wstrb_q;
    logic [1:0] bresp_q, rresp_q;
    logic wr_map, wr_busy_blk, wr_err, wr_en, rd_map, rd_err;
    logic autoinc_q, err_q, fill_busy;
    logic [FBUF_ADDR_WIDTH-1:0] fb_addr_q, px_addr_q;
    logic [FBUF_DATA_WIDTH-1:0] px_data_q;
    logic px_en_q;
    logic [AXI_DATA_WIDTH-1:0] scratch_q [NS];
`ifdef GPU_FILL_ENGINE_EN
    localparam logic [FBUF_ADDR_WIDTH:0] CNT_ONE = (FBUF_ADDR_WIDTH+1)'(1);
    logic busy_q;
    logic [FBUF_DATA_WIDTH-1:0] color_q;
    logic [FBUF_ADDR_WIDTH:0] count_q;
    assign fill_busy = busy_q;
`else
    assign fill_busy = 1'b0;
`endif
    logic unused_addr;
    assign unused_addr = ^{s_axi_ctrl_araddr[AXI_ADDRESS_WIDTH-1:8], s_axi_ctrl_araddr[1:0],
                           s_axi_ctrl_awaddr[AXI_ADDRESS_WIDTH-1:8], s_axi_ctrl_awaddr[1:0]};

    function automatic logic [AXI_DATA_WIDTH-1:0] strb_merge(input logic [AXI_DATA_WIDTH-1:0] old_v,
                                                             input logic [AXI_DATA_WIDTH-1:0] new_v,
                                                             input logic [SW-1:0] strb);
        logic [AXI_DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++) if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        return res;
    endfunction

    function automatic logic scratch_hit(input logic [5:0] off);
        return (off[5:3] == 3'b001) && ({29'd0, off[2:0]} < NUM_SCRATCH);
    endfunction

    assign aw_hs  = s_axi_ctrl_awvalid && awready_q;
    assign w_hs   = s_axi_ctrl_wvalid && wready_q;
    assign ar_hs  = s_axi_ctrl_arvalid && arready_q;
    assign ar_off = s_axi_ctrl_araddr[7:2];

    assign s_axi_ctrl_awready = awready_q;
    assign s_axi_ctrl_wready  = wready_q;
    assign s_axi_ctrl_bvalid  = (wstate_q == W_RESP);
    assign s_axi_ctrl_bresp   = bresp_q;
    assign s_axi_ctrl_arready = arready_q;
    assign s_axi_ctrl_rvalid  = (rstate_q == R_RESP);
    assign s_axi_ctrl_rdata   = rdata_q;
    assign s_axi_ctrl_rresp   = rresp_q;

    // While filling, the engine owns the BRAM port; FB_DATA pushes are rejected then.
`ifdef GPU_FILL_ENGINE_EN
    assign fbuf_en_wr = px_en_q | busy_q;
    assign fbuf_addr  = busy_q ? fb_addr_q : px_addr_q;
    assign fbuf_data  = busy_q ? color_q : px_data_q;
`else
    assign fbuf_en_wr = px_en_q;
    assign fbuf_addr  = px_addr_q;
    assign fbuf_data  = px_data_q;
`endif
    assign fbuf_wrea = fbuf_en_wr;

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        do_write  = 1'b0;
        case (wstate_q)
            W_IDLE, W_WAIT: begin
                if (aw_held_q && w_held_q) begin
                    do_write = 1'b1;
                    wstate_d = W_RESP;
                end else begin
                    if (aw_hs) aw_held_d = 1'b1;
                    if (w_hs)  w_held_d  = 1'b1;
                    if (aw_held_d || w_held_d) wstate_d = W_WAIT;
                end
            end
            W_RESP: begin
                if (s_axi_ctrl_bready) begin
                    wstate_d  = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_RESP;
            R_RESP:  if (s_axi_ctrl_rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_map      = 1'b1;
        wr_busy_blk = 1'b0;
        case (awoff_q)
            6'h00, 6'h01: wr_busy_blk = 1'b0;
            6'h02, 6'h03: wr_busy_blk = fill_busy;
`ifdef GPU_FILL_ENGINE_EN
            6'h04, 6'h05: wr_busy_blk = fill_busy;
`endif
            default: wr_map = scratch_hit(awoff_q);
        endcase
        wr_err = !wr_map || wr_busy_blk;
        wr_en  = do_write && !wr_err && (|wstrb_q);
    end

    always_comb begin
        rd_val = '0;
        rd_map = 1'b1;
        case (ar_off)
            6'h00: rd_val[0] = autoinc_q;
            6'h01: rd_val[1:0] = {err_q, fill_busy};
            6'h02: rd_val[FBUF_ADDR_WIDTH-1:0] = fb_addr_q;
            6'h03: rd_val = '0;
`ifdef GPU_FILL_ENGINE_EN
            6'h04: rd_val[FBUF_DATA_WIDTH-1:0] = color_q;
            6'h05: rd_val[FBUF_ADDR_WIDTH:0] = count_q;
`endif
            default: begin
                rd_map = scratch_hit(ar_off);
                if (rd_map)
                    for (int i = 0; i < NS; i++) if (ar_off[2:0] == 3'(i)) rd_val = scratch_q[i];
            end
        endcase
        rd_err = ar_hs && !rd_map;
    end

    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            awoff_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= (wstate_d != W_RESP) && !aw_held_d;
            wready_q  <= (wstate_d != W_RESP) && !w_held_d;
            arready_q <= (rstate_d == R_IDLE);
            if (aw_hs) awoff_q <= s_axi_ctrl_awaddr[7:2];
            if (w_hs) begin
                wdata_q <= s_axi_ctrl_wdata;
                wstrb_q <= s_axi_ctrl_wstrb;
            end
            if (do_write) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (ar_hs) begin
                rdata_q <= rd_map ? rd_val : '0;
                rresp_q <= rd_map ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            autoinc_q <= 1'b0;
            err_q     <= 1'b0;
            fb_addr_q <= '0;
            px_en_q   <= 1'b0;
            px_addr_q <= '0;
            px_data_q <= '0;
            for (int i = 0; i < NS; i++) scratch_q[i] <= '0;
`ifdef GPU_FILL_ENGINE_EN
            busy_q  <= 1'b0;
            color_q <= '0;
            count_q <= '0;
`endif
        end else begin
            px_en_q <= 1'b0;
`ifdef GPU_FILL_ENGINE_EN
            if (busy_q) begin
                fb_addr_q <= fb_addr_q + 1'b1;
                count_q   <= count_q - 1'b1;
                if (count_q == CNT_ONE) busy_q <= 1'b0;
            end
`endif
            if (wr_en) begin
                case (awoff_q)
                    6'h00: begin
                        if (wstrb_q[0]) autoinc_q <= wdata_q[0];
`ifdef GPU_FILL_ENGINE_EN
                        if (wstrb_q[0] && wdata_q[1] && !busy_q && (count_q != '0)) busy_q <= 1'b1;
`endif
                    end
                    6'h01: err_q <= 1'b0;
                    6'h02: fb_addr_q <= FBUF_ADDR_WIDTH'(strb_merge(AXI_DATA_WIDTH'(fb_addr_q), wdata_q, wstrb_q));
                    6'h03: begin
                        px_en_q   <= 1'b1;
                        px_addr_q <= fb_addr_q;
                        px_data_q <= wdata_q[FBUF_DATA_WIDTH-1:0];
                        if (autoinc_q) fb_addr_q <= fb_addr_q + 1'b1;
                    end
`ifdef GPU_FILL_ENGINE_EN
                    6'h04: color_q <= FBUF_DATA_WIDTH'(strb_merge(AXI_DATA_WIDTH'(color_q), wdata_q, wstrb_q));
                    6'h05: count_q <= (FBUF_ADDR_WIDTH+1)'(strb_merge(AXI_DATA_WIDTH'(count_q), wdata_q, wstrb_q));
`endif
                    default:
                        for (int i = 0; i < NS; i++)
                            if (awoff_q[2:0] == 3'(i)) scratch_q[i] <= strb_merge(scratch_q[i], wdata_q, wstrb_q);
                endcase
            end
            // An error on either channel in the same cycle as a STATUS clear still leaves it set.
            if ((do_write && wr_err) || rd_err) err_q <= 1'b1;
        end
    end
endmodule

// File: doc/axi4_lite_gpu_regs.md
Name: axi4_lite_gpu_regs

Overview:
Parametrised AXI4-Lite control slave for the GPU. It replaces the fixed stub responder with a real register file, a pixel-push port into the framebuffer BRAM (write-only side), and a hardware fill engine. It sits between the PS AXI GP master and the framebuffer BRAM write port.

Parameters:
AXI_ADDRESS_WIDTH, 32, AXI address width; only bits [7:2] are decoded, upper bits are ignored.
AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
FBUF_ADDR_WIDTH, 19, framebuffer pixel address width.
FBUF_DATA_WIDTH, 8, pixel width (1..32); taken from wdata LSBs.
NUM_SCRATCH, 4, number of general scratch registers (0..8).

Ports:
s_axi_ctrl_aclk  in  1  clock
s_axi_ctrl_aresetn  in  1  asynchronous active-low reset
s_axi_ctrl_araddr  in  AXI_ADDRESS_WIDTH  read address
s_axi_ctrl_arvalid / s_axi_ctrl_arready  in/out  1  AR handshake
s_axi_ctrl_rdata  out  AXI_DATA_WIDTH  read data
s_axi_ctrl_rresp  out  2  read response
s_axi_ctrl_rvalid / s_axi_ctrl_rready  out/in  1  R handshake
s_axi_ctrl_awaddr  in  AXI_ADDRESS_WIDTH  write address
s_axi_ctrl_awvalid / s_axi_ctrl_awready  in/out  1  AW handshake
s_axi_ctrl_wdata  in  AXI_DATA_WIDTH  write data
s_axi_ctrl_wstrb  in  AXI_DATA_WIDTH/8  byte strobes
s_axi_ctrl_wvalid / s_axi_ctrl_wready  in/out  1  W handshake
s_axi_ctrl_bresp  out  2  write response
s_axi_ctrl_bvalid / s_axi_ctrl_bready  out/in  1  B handshake
fbuf_en_wr  out  1  BRAM port enable
fbuf_wrea  out  1  BRAM write enable
fbuf_addr  out  FBUF_ADDR_WIDTH  pixel address
fbuf_data  out  FBUF_DATA_WIDTH  pixel data

Behaviour:
- Reset (async assert, sync deassert): every output 0; all registers 0; both FSMs in IDLE.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 AUTOINC (RW); bit1 FILL_START (write-1 pulse, reads 0).
  - 0x04 STATUS (RO): bit0 FILL_BUSY; bit1 ERR_STICKY, cleared by writing any value to 0x04.
  - 0x08 FB_ADDR (RW, FBUF_ADDR_WIDTH bits).
  - 0x0C FB_DATA (WO, reads 0).
  - 0x10 FILL_COLOR (RW).
  - 0x14 FILL_COUNT (RW, FBUF_ADDR_WIDTH+1 bits).
  - 0x20+4*i SCRATCH[i] (RW).
  - Unmapped offsets: SLVERR; reads return 0; writes have no effect; ERR_STICKY set.
- Byte strobes apply to every RW register. A write with all-zero strobe returns OKAY and has no effect.
- Write FSM (IDLE, WAIT, RESP):
  - IDLE: awready=wready=1. AW and W are accepted in either order or together; each channel is captured once, and its ready drops after its handshake.
  - WAIT: hold the captured channel until the other channel arrives.
  - The cycle after both are held: perform the action, assert bvalid → RESP.
  - RESP: hold bvalid and bresp until bready, then → IDLE. No AW or W is accepted while in RESP.
- FB_DATA write with nonzero strobe:
  - One cycle with fbuf_en_wr=fbuf_wrea=1, fbuf_addr=FB_ADDR, fbuf_data=wdata[FBUF_DATA_WIDTH-1:0], coincident with bvalid rising.
  - If AUTOINC=1, FB_ADDR increments by 1 and wraps modulo 2^FBUF_ADDR_WIDTH.
- Read path:
  - arready=1 in IDLE. After the AR handshake, rvalid=1 next cycle with registered rdata and rresp.
  - rvalid, rdata and rresp are held until rready, then → IDLE.
  - Read and write paths are independent and may overlap.
- Fill engine:
  - FILL_START while idle with FILL_COUNT>0: busy=1. Then one pixel per cycle: fbuf_addr=FB_ADDR, fbuf_data=FILL_COLOR; FB_ADDR increments (wraps) each pixel, and FILL_COUNT decrements.
  - Busy clears the cycle after the last pixel. Final FB_ADDR = start+count (mod).
  - FILL_COUNT=0: no writes, busy stays 0.
  - FILL_START while busy: ignored, OKAY.
  - While busy, writes to FB_DATA, FB_ADDR, FILL_COLOR or FILL_COUNT: SLVERR, no effect, ERR_STICKY set. Reads remain legal.
- Reset mid-fill or mid-transaction: immediate abort; BRAM enables drop asynchronously.

Optional Feature:
GPU_FILL_ENGINE_EN.
- Defined: fill engine and registers 0x10/0x14 present as above.
- Undefined:
  - 0x10/0x14 are unmapped (SLVERR).
  - CTRL bit1 is ignored.
  - FILL_BUSY reads 0.
  - The BRAM port is driven only by FB_DATA writes.

Test Plan:
- Reset, then read 0x04 → rdata=0, OKAY; all outputs 0 during reset.
- W presented 3 cycles before AW to 0x20, data 0xA5A5A5A5, strobe 0xF; read back → 0xA5A5A5A5, OKAY, single bvalid.
- CTRL=1, FB_ADDR=0x7FFFF, two FB_DATA writes 0x12, 0x34 → BRAM writes at 0x7FFFF then 0x00000; FB_ADDR reads 0x00001.
- FB_ADDR=0x100, FILL_COLOR=0x3C, FILL_COUNT=4, FILL_START → 4 consecutive BRAM writes at 0x100..0x103 with data 0x3C; busy for 4 cycles; FB_ADDR=0x104.
- During fill, write FB_DATA → bresp=SLVERR, no extra BRAM write, STATUS bit1=1. Write 0x04 → bit1=0.
- Read 0x3C with NUM_SCRATCH=4 and rready held low 5 cycles → rresp=SLVERR, rdata=0, rvalid held stable until rready.
